aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_round_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// AES round controller shared types.
// FSM states, block type and default round count.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } aes_state_e;

  typedef logic [127:0] aes_block_t;

  localparam int AES_ROUNDS = 10;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: drives an external key ROM and round datapath.
// Define AES_CTRL_DECRYPT_EN to add decrypt_i and reversed key order.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES_ROUNDS
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         clear_i,
`ifdef AES_CTRL_DECRYPT_EN
  input  logic         decrypt_i,
`endif
  input  logic [127:0] block_i,
  output logic         ready_o,
  output logic [3:0]   round_o,
  input  logic [127:0] key_i,
  output logic [127:0] state_o,
  output logic         final_o,
  input  logic [127:0] rdata_i,
  output logic         valid_o,
  output logic [127:0] data_o,
  input  logic         ready_i
);

  localparam logic [3:0] LP_LAST = 4'(ROUNDS);

  aes_state_e r_fsm;
  aes_state_e w_fsm_nxt;
  aes_block_t r_blk;
  aes_block_t w_blk_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_in_round;
  logic       w_accept;

  assign w_in_round = (r_fsm == S_ROUND);
  assign w_accept   = ready_o & start_i & ~clear_i;

  // State, block and round counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_fsm <= S_IDLE;
      r_blk <= '0;
      r_cnt <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_blk <= w_blk_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next state: clear aborts; counter stops at the last round
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_blk_nxt = r_blk;
    w_cnt_nxt = r_cnt;
    if (clear_i) begin
      w_fsm_nxt = S_IDLE;
      w_cnt_nxt = '0;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          if (start_i) begin
            w_blk_nxt = block_i ^ key_i;
            w_cnt_nxt = 4'd1;
            w_fsm_nxt = S_ROUND;
          end
        end
        S_ROUND: begin
          w_blk_nxt = rdata_i;
          if (r_cnt == LP_LAST) begin
            w_fsm_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            w_fsm_nxt = S_IDLE;
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_fsm_nxt = S_IDLE;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign ready_o = (r_fsm == S_IDLE);
  assign valid_o = (r_fsm == S_DONE);
  assign state_o = r_blk;
  assign data_o  = r_blk;
  assign final_o = w_in_round & (r_cnt == LP_LAST);

`ifdef AES_CTRL_DECRYPT_EN
  logic r_dec;

  // Direction latched when a block is accepted
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_dec <= 1'b0;
    end else if (w_accept) begin
      r_dec <= decrypt_i;
    end
  end

  // Decrypt walks the key schedule from the top down
  always_comb begin
    round_o = '0;
    if (w_in_round) begin
      round_o = r_dec ? (LP_LAST - r_cnt) : r_cnt;
    end else if (ready_o && decrypt_i) begin
      round_o = LP_LAST;
    end
  end
`else
  logic w_unused;

  assign w_unused = w_accept;
  assign round_o  = w_in_round ? r_cnt : 4'd0;
`endif

endmodule
